// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, beat count,
// port identifiers and big-endian byte-lane helpers.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NBEATS = 4;
  localparam logic [1:0] LAST_BEAT = 2'(NBEATS - 1);

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Beat 0 carries the most significant byte (big-endian word layout).
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  // Replaces one byte lane of a word, using the same beat-to-lane mapping.
  function automatic logic [31:0] set_byte_lane(input logic [31:0] word, input logic [1:0] sel,
                                                input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (sel)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way arbiter: picks the cpu or dbg port. In round-robin mode a tie goes
// to the port that was not served last (the pointer); otherwise cpu wins ties.
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic ptr,
  input  logic rr_mode,
  output logic winner
);

  // Winner selection; with no request the result is unused by the parent.
  always_comb begin
    winner = PORT_CPU;
    if (cpu_req && dbg_req) begin
      winner = rr_mode ? ~ptr : PORT_CPU;
    end else if (dbg_req) begin
      winner = PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a byte-wide data memory between the cpu and dbg word ports. Each
// granted word access is latched and then sequenced as four byte beats,
// followed by a one-cycle ack to the winning port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDRW = 5,
  parameter int RR    = 1
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             cpureq,
  input  logic             cpuwe,
  input  logic [ADDRW-1:0] cpuaddr,
  input  logic [31:0]      cpuwdata,
  output logic             cpuack,
  output logic [31:0]      cpurdata,

  input  logic             dbgreq,
  input  logic             dbgwe,
  input  logic [ADDRW-1:0] dbgaddr,
  input  logic [31:0]      dbgwdata,
  output logic             dbgack,
  output logic [31:0]      dbgrdata,

  output logic [ADDRW-1:0] memaddr,
  output logic             memwe,
  output logic [7:0]       memwdata,
  input  logic [7:0]       memrdata,

  output logic             busy
);

  localparam logic RR_MODE = (RR != 0);

  state_t           state;
  state_t           next_state;
  logic [1:0]       cnt;
  logic             winner;
  logic             grant;
  logic             rr_ptr;
  logic             lat_we;
  logic [ADDRW-1:0] lat_addr;
  logic [31:0]      lat_wdata;
  logic             any_req;
  logic             sel_we;
  logic [ADDRW-1:0] sel_addr;
  logic [31:0]      sel_wdata;

  assign any_req   = cpureq | dbgreq;
  assign sel_we    = (grant == PORT_DBG) ? dbgwe    : cpuwe;
  assign sel_addr  = (grant == PORT_DBG) ? dbgaddr  : cpuaddr;
  assign sel_wdata = (grant == PORT_DBG) ? dbgwdata : cpuwdata;

  rr_arbiter2 u_arb (
    .cpu_req (cpureq),
    .dbg_req (dbgreq),
    .ptr     (rr_ptr),
    .rr_mode (RR_MODE),
    .winner  (grant)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: grant from IDLE, four beats, one DONE cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = BEAT;
      BEAT:    if (cnt == LAST_BEAT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Transaction latch, registered memory interface and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      winner    <= PORT_CPU;
      rr_ptr    <= PORT_DBG;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      memaddr   <= '0;
      memwe     <= 1'b0;
      memwdata  <= '0;
      cpurdata  <= '0;
      dbgrdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            winner    <= grant;
            cnt       <= '0;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            memaddr   <= sel_addr;
            memwe     <= sel_we;
            memwdata  <= byte_lane(sel_wdata, 2'd0);
          end
        end
        BEAT: begin
          if (!lat_we) begin
            if (winner == PORT_CPU) begin
              cpurdata <= set_byte_lane(cpurdata, cnt, memrdata);
            end else begin
              dbgrdata <= set_byte_lane(dbgrdata, cnt, memrdata);
            end
          end
          if (cnt == LAST_BEAT) begin
            memwe <= 1'b0;
          end else begin
            cnt      <= cnt + 2'd1;
            memaddr  <= lat_addr + ADDRW'(cnt + 2'd1);
            memwdata <= byte_lane(lat_wdata, cnt + 2'd1);
          end
        end
        DONE: begin
          rr_ptr <= winner;
          memwe  <= 1'b0;
        end
        default: memwe <= 1'b0;
      endcase
    end
  end

  // Outputs decoded from state: ack pulse to the winner, busy when not idle.
  always_comb begin
    cpuack = 1'b0;
    dbgack = 1'b0;
    busy   = (state != IDLE);
    if (state == DONE) begin
      if (winner == PORT_CPU) cpuack = 1'b1;
      else                    dbgack = 1'b1;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the byte-wide data memory (32 x 8-bit, big-endian words: lowest address holds bits [31:24]) between two word requesters: the processor port (cpu) and a debug/loader port (dbg).
- Arbitrates between the two ports, then sequences each 32-bit access as four byte beats.
- Sits between the processor datapath's load/store path and the data memory array. The processor stalls on cpureq until cpuack.

Parameters:
- ADDRW, 5, byte address width. Memory depth is 2**ADDRW. Beat addresses wrap modulo 2**ADDRW.
- RR, 1, arbitration mode. 1 = round-robin. 0 = fixed priority, cpu wins.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- cpureq  in  1  cpu word access request; held until cpuack.
- cpuwe  in  1  1 = write, 0 = read.
- cpuaddr  in  ADDRW  byte address of the word's MSB.
- cpuwdata  in  32  write data.
- cpuack  out  1  one-cycle completion pulse.
- cpurdata  out  32  read data; valid from cpuack and held until the next cpu read completes.
- dbgreq, dbgwe, dbgaddr, dbgwdata, dbgack, dbgrdata: same as the cpu port, for the dbg port.
- memaddr  out  ADDRW  byte address to the memory.
- memwe  out  1  byte write enable; the memory writes on posedge.
- memwdata  out  8  byte write data.
- memrdata  in  8  combinational byte read of mem[memaddr].
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate) sets:
  - state = IDLE, rr pointer = dbg (so cpu wins first);
  - cpuack = dbgack = 0, memwe = 0, memaddr = 0, memwdata = 0, busy = 0;
  - cpurdata = dbgrdata = 0.
- FSM states: IDLE, BEAT, DONE.
  - IDLE -> BEAT at the posedge where any req = 1. At that edge: latch the winner id, we, addr and wdata; set beat counter cnt = 0.
  - BEAT, cnt 0..3: memaddr = latched addr + cnt, truncated to ADDRW bits.
    - Write: memwe = 1 and memwdata = wdata byte (cnt=0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]).
    - Read: memwe = 0; memrdata is captured into the winner's rdata byte lane (same mapping) at the end-of-beat posedge.
  - BEAT cnt = 3 -> DONE.
  - DONE: winner's ack = 1 for exactly this cycle; rdata is complete (reads). DONE -> IDLE on the next posedge; rr pointer := winner.
- Latency: req sampled at edge 0; beats occupy cycles 1-4; ack in cycle 5; the next grant is possible at the end of cycle 6. Throughput is one word per 6 cycles.
- Arbitration:
  - Single request: grant it.
  - Both requesting with RR = 1: grant the port that is not the rr pointer.
  - Both requesting with RR = 0: cpu.
  - The loser keeps req high and is served next.
- Request rules:
  - Inputs are latched at grant. Changes to addr, we, wdata or req during BEAT/DONE are ignored, and the transaction always completes.
  - req still high in the cycle after ack is a new request, serviced normally.
- Port isolation: the non-winning port's ack is 0 and its rdata is unchanged. A write never alters either rdata.
- Wrap: addr = 2**ADDRW - 2 touches bytes 30, 31, 0, 1.
- Reset mid-operation: abort at once with memwe = 0. Bytes already written stay written; no ack is issued.
- memaddr, memwe and memwdata are driven only from registers (no combinational path from req inputs). In IDLE and DONE, memwe = 0.

Decomposition:
- Shared package contains:
  - state encoding (IDLE/BEAT/DONE);
  - NBEATS = 4;
  - port ids PORT_CPU = 0, PORT_DBG = 1;
  - byte-lane select function (cnt -> bit slice).
- One sub-module: rr_arbiter2. Inputs: two requests, pointer, RR mode. Output: winner id. Combinational, with the pointer register in the parent.

Test Plan:
- Read: mem[8..11] = 12 34 56 78; cpu read addr 8 -> memaddr 8, 9, 10, 11 in cycles 1-4; cpuack in cycle 5; cpurdata = 32'h12345678; dbgack stays 0.
- Write with wrap: dbg write addr 30, data 32'hAABBCCDD -> mem[30] = AA, mem[31] = BB, mem[0] = CC, mem[1] = DD; dbgack once; cpurdata and dbgrdata unchanged.
- Contention: both req asserted from reset and held -> cpu served first, then dbg, then cpu (alternating). With RR = 0 and both held: cpu served every time, dbg never acked.
- Reset mid-write: cpu write addr 4, data 32'h11223344; reset asserted in the cycle-3 beat (cnt = 2) -> memwe = 0 immediately; mem[4] = 11, mem[5] = 22; mem[6..7] unchanged; no cpuack; busy = 0.
- Input change mid-op: cpu read addr 8; cpuaddr changed to 16 and cpureq dropped in cycle 2 -> access still reads bytes 8-11; ack in cycle 5.
- Back-to-back: cpureq held after ack with addr 12 -> second grant at the end of cycle 6; memaddr 12-15 in cycles 7-10; ack in cycle 11.
